maxpool2x2_stream: RTL and testbench
====================================

// Module: maxpool2x2_stream
// PURPOSE
//  Streaming 2x2 max-pool (stride 2) directly downstream of reluArr.
//  Each accepted beat is one row segment of array_size lanes.
//  Horizontal max over lane pairs (2k,2k+1); vertical max across consecutive image rows via a line buffer.
//  Emits one beat of array_size/2 lanes per beat of every odd row; feeds the next conv layer's input buffer.
// PARAMETERS
//  data_width  8  bits per lane, signed two's complement
//  array_size  8  lanes per input beat; must be even
//  row_beats   4  beats per image row; line buffer depth; >=1
// PORTS
//  clk        in   1                          rising-edge clock
//  rst_n      in   1                          async active-low reset
//  clr        in   1                          sync frame restart: clears counters/parity, drops pending output
//  in_valid   in   1                          input beat valid
//  in_ready   out  1                          block accepts beat this cycle
//  in_data    in   array_size*data_width      lane i at bits [i*data_width +: data_width]
//  out_valid  out  1                          pooled beat valid
//  out_ready  in   1                          consumer accepts pooled beat
//  out_data   out  (array_size/2)*data_width  lane k = max of 2x2 window k
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0; out_data=0; beat_cnt=0; row_par=0 (even); line buffer cleared to 0.
//  Handshake:
//   - Accept = in_valid & in_ready.
//   - in_ready = !clr & (!out_valid | out_ready).
//   - out_data held stable while out_valid & !out_ready.
//  Horizontal step (combinational): h[k] = signed max(in[2k], in[2k+1]).
//   - Equal values pass unchanged.
//   - No width growth; out lane width = data_width.
//  Even row (row_par=0), on accept: lbuf[beat_cnt] <= h. No output produced.
//  Odd row (row_par=1), on accept:
//   - out_data[k] <= signed max(lbuf[beat_cnt][k], h[k]); out_valid <= 1 next cycle.
//   - Latency: 1 clk, accept edge to out_valid.
//  Output drop: out_valid falls on out_ready unless a new odd-row beat is accepted in the same cycle.
//   - Back-to-back odd-row beats sustain out_valid=1 at full rate.
//  Counters, on accept:
//   - beat_cnt increments; it wraps row_beats-1 -> 0.
//   - row_par toggles on wrap.
//   - No frame-length limit; rows pair continuously until clr.
//  clr=1 (sync):
//   - beat_cnt=0, row_par=0, out_valid=0.
//   - The input beat in that cycle is not accepted (in_ready=0).
//   - clr wins over simultaneous in_valid/out_ready.
//   - Line buffer contents are kept; they are overwritten before use.
//  Reset or clr mid-row: a partial even row is discarded. The next accepted beat is row 0, beat 0.
//  Stall: with out_valid=1 and out_ready=0, in_ready=0, so no input is lost and no state advances.
//  Even-row beats also stall while the output is blocked (simple rule, no bypass).
// TESTING
//  Config for all cases: data_width=8, array_size=4, row_beats=2. Values listed lane0 first.
//  1 Basic pool:
//     Stimulus: rows [3,-1,5,2],[0,0,7,1] then [4,2,1,6],[-2,-3,9,0], with out_ready=1.
//     Expect: out [4,6] then [0,9], each 1 clk after its odd-row accept; no output during row 0.
//  2 Signed/extremes:
//     Stimulus: row0 [-128,-128,127,127], row1 [-1,-128,126,-128], with row_beats=1.
//     Expect: out [-1,127].
//  3 Backpressure:
//     Stimulus: hold out_ready=0 after the first pooled beat.
//     Expect: out_data stable; in_ready=0. Release -> next beat correct, none lost or duplicated over 4 rows.
//  4 Wrap/parity:
//     Stimulus: 8 rows of random data.
//     Expect: exactly 4*row_beats outputs matching a reference model; beat_cnt and row_par wrap correctly.
//  5 clr mid-row:
//     Stimulus: after 1 beat of row0, assert clr together with in_valid.
//     Expect: beat not accepted; the next two rows pool from scratch.
//  6 Async reset mid-output:
//     Stimulus: drop rst_n while out_valid=1 and out_ready=0.
//     Expect: out_valid=0 and out_data=0 immediately, without waiting for a clk edge; restart identical to case 1.

Source files
------------

// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
//
// Streaming 2x2 / stride-2 max-pool stage intended to sit directly behind the
// ReLU array. Each accepted input beat carries one row segment of array_size
// signed lanes. Adjacent lane pairs (2k, 2k+1) are reduced horizontally in
// the same cycle. The two rows of each row pair are combined through a line
// buffer holding the horizontally reduced even row. Every beat of an odd row
// produces one pooled beat of array_size/2 lanes one clock after it is
// accepted.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous frame restart (counters, parity, pending output)
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted this cycle when in_valid is also high
//   in_data    in   array_size lanes, lane i at [i*data_width +: data_width]
//   out_valid  out  pooled beat valid
//   out_ready  in   consumer takes the pooled beat
//   out_data   out  array_size/2 lanes, lane k = max of 2x2 window k
// -----------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int data_width = 8,
    parameter int array_size = 8,
    parameter int row_beats  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [array_size*data_width-1:0]      in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [(array_size/2)*data_width-1:0]  out_data
);

    localparam int HALF  = array_size / 2;
    localparam int OUT_W = HALF * data_width;
    // Keep the counter at least one bit wide so row_beats == 1 still elaborates.
    localparam int CNT_W = (row_beats > 1) ? $clog2(row_beats) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(row_beats - 1);

    // Signed maximum of two lanes; on a tie the first operand is returned,
    // which is the same bit pattern either way.
    function automatic logic [data_width-1:0] smax(
        input logic [data_width-1:0] a,
        input logic [data_width-1:0] b
    );
        logic [data_width-1:0] m;
        if ($signed(a) >= $signed(b)) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_wrap;
    logic [OUT_W-1:0]     w_h;
    logic [OUT_W-1:0]     w_lbuf_rd;
    logic [OUT_W-1:0]     w_pool;

    logic [CNT_W-1:0]     r_beat_cnt;
    logic                 r_row_par;
    logic [OUT_W-1:0]     r_lbuf [row_beats];
    logic                 r_out_valid;
    logic [OUT_W-1:0]     r_out_data;

    // A held output blocks every input beat, even-row beats included, so no
    // state advances while the consumer stalls.
    assign w_ready   = !clr && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && w_ready;
    assign w_wrap    = (r_beat_cnt == LAST_BEAT);
    assign w_lbuf_rd = r_lbuf[r_beat_cnt];

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Horizontal reduction of each lane pair of the incoming beat.
    always_comb begin
        w_h = '0;
        for (int k = 0; k < HALF; k++) begin
            w_h[k*data_width +: data_width] =
                smax(in_data[(2*k)*data_width +: data_width],
                     in_data[(2*k+1)*data_width +: data_width]);
        end
    end

    // Vertical reduction against the stored even-row beat at the same column.
    always_comb begin
        w_pool = '0;
        for (int k = 0; k < HALF; k++) begin
            w_pool[k*data_width +: data_width] =
                smax(w_lbuf_rd[k*data_width +: data_width],
                     w_h[k*data_width +: data_width]);
        end
    end

    // Line buffer: captures horizontally reduced even-row beats. clr leaves it
    // alone because every entry is rewritten by the even row before it is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < row_beats; i++) begin
                r_lbuf[i] <= '0;
            end
        end else if (w_accept && !r_row_par) begin
            r_lbuf[r_beat_cnt] <= w_h;
        end
    end

    // Beat position within the row and row parity; both restart on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_row_par  <= 1'b0;
        end else if (clr) begin
            r_beat_cnt <= '0;
            r_row_par  <= 1'b0;
        end else if (w_accept) begin
            if (w_wrap) begin
                r_beat_cnt <= '0;
                r_row_par  <= ~r_row_par;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1'b1);
            end
        end
    end

    // Output register: loaded by every odd-row accept, otherwise emptied when
    // the consumer takes it. An odd-row accept in the same cycle as a take
    // keeps out_valid high so back-to-back odd beats stream at full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
        end else if (w_accept && r_row_par) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_pool;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2x2_stream
//
// Directed and randomized bench for maxpool2x2_stream. Instance u_dut uses
// array_size=4, row_beats=2; instance u_dut_b uses row_beats=1 for the
// signed-extremes case. Expected pooled beats come from a model that keeps the
// raw even-row beats and takes the maximum of the four window values.
// -----------------------------------------------------------------------------
module tb_maxpool2x2_stream;

    localparam int DW = 8;
    localparam int AS = 4;
    localparam int RB = 2;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    logic        b_clr;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_out_data;

    int          n_assert;
    int          n_fail;
    int          m_cnt;
    int          out_cnt;
    logic [31:0] m_prev [RB];
    logic [15:0] exp_q [$];
    logic        acc_flag;
    logic        rnd_ready;
    logic [15:0] hold;

    maxpool2x2_stream #(.data_width(DW), .array_size(AS), .row_beats(RB)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    maxpool2x2_stream #(.data_width(DW), .array_size(AS), .row_beats(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        logic [7:0] l0, l1, l2, l3;
        l0 = a[7:0]; l1 = b[7:0]; l2 = c[7:0]; l3 = d[7:0];
        return {l3, l2, l1, l0};
    endfunction

    // Max over the four values of each 2x2 window (two lanes of each row).
    function automatic logic [15:0] pool(input logic [31:0] top, input logic [31:0] bot);
        logic [15:0] r;
        int          m;
        int          v [4];
        r = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            v[0] = int'($signed(top[16*k +: 8]));
            v[1] = int'($signed(top[16*k+8 +: 8]));
            v[2] = int'($signed(bot[16*k +: 8]));
            v[3] = int'($signed(bot[16*k+8 +: 8]));
            m = v[0];
            for (int j = 1; j < 4; j++) if (v[j] > m) m = v[j];
            r[8*k +: 8] = m[7:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] d);
        int row;
        int beat;
        row  = m_cnt / RB;
        beat = m_cnt % RB;
        if (row % 2 == 0) m_prev[beat] = d;
        else exp_q.push_back(pool(m_prev[beat], d));
        m_cnt++;
    endtask

    // One clock, entered and left at a falling edge; handshakes are sampled
    // just before the rising edge and applied to the model after it.
    task automatic tick();
        logic        fo, fi, cl;
        logic [31:0] d;
        logic [15:0] od;
        int          n;
        #1;
        fo = out_valid & out_ready;
        fi = in_valid & in_ready;
        cl = clr;
        d  = in_data;
        od = out_data;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            acc_flag = 1'b0;
        end else begin
            if (fo) begin
                n = exp_q.size();
                chk("out_expected", 64'(n != 0), 64'(1));
                if (n != 0) chk("out_data", 64'(od), 64'(exp_q.pop_front()));
                out_cnt++;
            end
            if (cl) model_reset();
            else if (fi) model_accept(d);
            acc_flag = fi & !cl;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 40 && !done; t++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            done = acc_flag;
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(done), 64'(1));
    endtask

    task automatic do_clr();
        clr      = 1'b1;
        in_valid = 1'b0;
        tick();
        clr      = 1'b0;
        out_cnt  = 0;
    endtask

    task automatic run_case1(input string tag);
        out_ready = 1'b1;
        rnd_ready = 1'b0;
        send(pk(3, -1, 5, 2));
        chk({tag, "_r0b0_valid"}, 64'(out_valid), 64'(0));
        send(pk(0, 0, 7, 1));
        chk({tag, "_r0b1_valid"}, 64'(out_valid), 64'(0));
        send(pk(4, 2, 1, 6));
        chk({tag, "_r1b0_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_r1b0_data"}, 64'(out_data), 64'(16'h0604));
        send(pk(-2, -3, 9, 0));
        chk({tag, "_r1b1_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_r1b1_data"}, 64'(out_data), 64'(16'h0900));
        tick();
        chk({tag, "_drained"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        n_assert = 0; n_fail = 0; out_cnt = 0; acc_flag = 1'b0; rnd_ready = 1'b0;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        b_clr = 1'b0; b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Case 1: basic pool
        run_case1("c1");

        // Case 2: signed extremes on the row_beats=1 instance
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = pk(-128, -128, 127, 127);
        #1 chk("c2_in_ready", 64'(b_in_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        chk("c2_row0_valid", 64'(b_out_valid), 64'(0));
        b_in_data = pk(-1, -128, 126, -128);
        @(posedge clk); @(negedge clk);
        b_in_valid = 1'b0;
        chk("c2_valid", 64'(b_out_valid), 64'(1));
        chk("c2_data", 64'(b_out_data), 64'(16'h7fff));

        // Case 3: backpressure over 4 rows
        out_ready = 1'b1;
        do_clr();
        send($urandom); send($urandom); send($urandom);
        chk("c3_first_valid", 64'(out_valid), 64'(1));
        chk("c3_first_data", 64'(out_data), 64'(exp_q[0]));
        out_ready = 1'b0;
        hold      = out_data;
        in_valid  = 1'b1;
        in_data   = $urandom;
        for (int i = 0; i < 3; i++) begin
            #1 chk("c3_stall_in_ready", 64'(in_ready), 64'(0));
            tick();
            chk("c3_stall_valid", 64'(out_valid), 64'(1));
            chk("c3_stall_data", 64'(out_data), 64'(hold));
        end
        out_ready = 1'b1;
        send(in_data);
        rnd_ready = 1'b1;
        for (int i = 0; i < 4; i++) send($urandom);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("c3_out_count", 64'(out_cnt), 64'(4));
        chk("c3_queue_empty", 64'(exp_q.size()), 64'(0));

        // Case 4: 8 random rows with random backpressure
        do_clr();
        rnd_ready = 1'b1;
        for (int i = 0; i < 8 * RB; i++) send($urandom);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("c4_out_count", 64'(out_cnt), 64'(4 * RB));
        chk("c4_queue_empty", 64'(exp_q.size()), 64'(0));

        // Case 5: clr mid-row together with in_valid
        do_clr();
        send($urandom);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = $urandom;
        #1 chk("c5_clr_in_ready", 64'(in_ready), 64'(0));
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        out_cnt  = 0;
        chk("c5_after_clr_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 2 * RB; i++) begin
            send($urandom);
            chk("c5_valid", 64'(out_valid), 64'((i >= RB) ? 1 : 0));
        end
        tick();
        chk("c5_out_count", 64'(out_cnt), 64'(RB));
        chk("c5_queue_empty", 64'(exp_q.size()), 64'(0));

        // Case 6: async reset while an output is held
        do_clr();
        send($urandom); send($urandom); send($urandom);
        out_ready = 1'b0;
        chk("c6_pre_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("c6_async_valid", 64'(out_valid), 64'(0));
        chk("c6_async_data", 64'(out_data), 64'(0));
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        model_reset();
        out_cnt = 0;
        run_case1("c6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
